// File: rtl/aes_iter_encrypt.sv
// aes_iter_encrypt: iterative AES encryptor (AES-128 or AES-256 by KEY_BITS).
// One cipher round per clock, with the key schedule computed alongside each round.
// Blocks enter and leave over valid/ready handshakes.
// Optional build macro: AES_ENC_ZEROIZE_EN. When defined, the state register, key
// register and dataout are cleared when a finished block is handed off and the
// core goes idle.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | one AES round per clock; busy high
// DONE  | ciphertext on dataout with out_valid high until out_ready
module aes_iter_encrypt #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        datain,
    input  logic [KEY_BITS-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        dataout,
    output logic                busy
);

    localparam int         NR   = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR_L = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return r;
    endfunction

    // byte n of the block sits at row n%4, column n/4; row r rotates left by r
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                   a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                   a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                   xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // new 4-word block: prev4 is the block one key-length back, last is the newest word
    function automatic logic [127:0] expand_block(input logic [127:0] prev4,
                                                  input logic [31:0]  last,
                                                  input logic         rot,
                                                  input logic [7:0]   rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = rot ? (sub_word({last[23:0], last[31:24]}) ^ {rc, 24'h0}) : sub_word(last);
        w0 = prev4[127:96] ^ t;
        w1 = prev4[95:64]  ^ w0;
        w2 = prev4[63:32]  ^ w1;
        w3 = prev4[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t                fsm_q;
    logic [127:0]          st_q;
    logic [KEY_BITS-1:0]   key_q;
    logic [3:0]            rnd_q;
    logic [127:0]          dataout_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [127:0]          sr;
    logic [127:0]          round_key;
    logic [KEY_BITS-1:0]   key_nxt;
    logic [127:0]          round_out;
    logic                  last_round;
    logic                  accept;

    assign in_ready  = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign dataout   = dataout_q;
    assign busy      = busy_q;

    // one cipher round; the final round skips MixColumns
    always_comb begin
        sr         = shift_rows(sub_bytes(st_q));
        last_round = (rnd_q == NR_L);
        round_out  = (last_round ? sr : mix_columns(sr)) ^ round_key;
    end

    if (KEY_BITS == 256) begin : g_ks256
        // 256-bit window: round 1 uses the lower key half, later rounds slide by one block
        always_comb begin
            round_key = key_q[127:0];
            key_nxt   = key_q;
            if (rnd_q != 4'd1) begin
                round_key = expand_block(key_q[255:128], key_q[31:0], !rnd_q[0],
                                         rcon((rnd_q >> 1) - 4'd1));
                key_nxt   = {key_q[127:0], round_key};
            end
        end
    end else begin : g_ks128
        // AES-128: every round derives the next round key from the current one
        always_comb begin
            round_key = expand_block(key_q, key_q[31:0], 1'b1, rcon(rnd_q - 4'd1));
            key_nxt   = round_key;
        end
    end

    // control FSM, round counter, datapath registers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            dataout_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            st_q        <= datain ^ key[KEY_BITS-1 -: 128];
            key_q       <= key;
            rnd_q       <= 4'd1;
            fsm_q       <= RUN;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (fsm_q)
                RUN: begin
                    st_q  <= round_out;
                    key_q <= key_nxt;
                    if (last_round) begin
                        fsm_q       <= DONE;
                        rnd_q       <= '0;
                        dataout_q   <= round_out;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
`ifdef AES_ENC_ZEROIZE_EN
                        st_q        <= '0;
                        key_q       <= '0;
                        dataout_q   <= '0;
`endif
                    end
                end
                IDLE: begin
                    fsm_q <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// tb_aes_iter_encrypt: directed + random checks of aes_iter_encrypt (AES-128 and AES-256
// instances) against a FIPS-197 reference model built from GF(2^8) arithmetic.
module tb_aes_iter_encrypt;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [127:0] datain_a, dataout_a, key_a;
    logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [127:0] datain_b, dataout_b;
    logic [255:0] key_b;

    aes_iter_encrypt #(.KEY_BITS(128)) dut128 (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .datain(datain_a), .key(key_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .dataout(dataout_a), .busy(busy_a)
    );

    aes_iter_encrypt #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .datain(datain_b), .key(key_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .dataout(dataout_b), .busy(busy_b)
    );

    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb [0:255];

    task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl1(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // S-box = multiplicative inverse in GF(2^8) followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, r1, r2, r3, r4;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
            sb[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // FIPS-197 Cipher(); the key is left-aligned in k, nk = 4 or 8 words
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int nk);
        logic [31:0]  w [0:59];
        logic [7:0]   s [0:3][0:3];
        logic [7:0]   t [0:3][0:3];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
        for (int rd = 1; rd <= nr; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd == nr) s[r][c] = t[r][c];
                    else s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                   ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    s[r][c] = s[r][c] ^ w[4*rd + c][31 - 8*r -: 8];
                end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [127:0] d, input logic [255:0] k);
        if (sel == 0) begin in_valid_a = v; datain_a = d; key_a = k[255:128]; end
        else begin in_valid_b = v; datain_b = d; key_b = k; end
    endtask

    task automatic set_or(input int sel, input logic v);
        if (sel == 0) out_ready_a = v; else out_ready_b = v;
    endtask

    function automatic logic get_ov(input int sel);
        return (sel != 0) ? out_valid_b : out_valid_a;
    endfunction
    function automatic logic get_ir(input int sel);
        return (sel != 0) ? in_ready_b : in_ready_a;
    endfunction
    function automatic logic get_bz(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction
    function automatic logic [127:0] get_do(input int sel);
        return (sel != 0) ? dataout_b : dataout_a;
    endfunction

    // accept one block and wait (bounded) for out_valid; lat = edges from accept to out_valid
    task automatic encrypt(input int sel, input logic [127:0] pt, input logic [255:0] k, output int lat);
        int n;
        n = 0;
        while (!get_ir(sel) && n < 50) begin @(posedge clk); #1; n++; end
        check_b("ready_before_accept", get_ir(sel), 1'b1);
        set_in(sel, 1'b1, pt, k);
        @(posedge clk); #1;
        set_in(sel, 1'b0, rnd128(), {rnd128(), rnd128()});
        check_b("busy_after_accept", get_bz(sel), 1'b1);
        lat = 0;
        while (!get_ov(sel) && lat < 40) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic handshake(input int sel);
        set_or(sel, 1'b1);
        @(posedge clk); #1;
        set_or(sel, 1'b0);
        check_b("out_valid_after_handshake", get_ov(sel), 1'b0);
        check_b("ready_in_idle", get_ir(sel), 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, m;
        logic [127:0] pt, ct, pt2;
        logic [255:0] k, k2;

        build_sbox();
        rst = 1'b1;
        set_in(0, 1'b0, '0, '0); set_in(1, 1'b0, '0, '0);
        out_ready_a = 1'b0; out_ready_b = 1'b0;

        #3;
        check_b("reset_in_ready_128", in_ready_a, 1'b0);
        check_b("reset_in_ready_256", in_ready_b, 1'b0);
        check_b("reset_out_valid", out_valid_a, 1'b0);
        check_b("reset_busy", busy_a, 1'b0);
        check_w("reset_dataout", dataout_a, '0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_b("ready_after_reset", in_ready_a, 1'b1);

        // FIPS-197 appendix B
        encrypt(0, PT_B, {KEY_B, 128'h0}, lat);
        check_i("latency_b", lat, 10);
        check_w("ct_fips_b", dataout_a, CT_B);
        check_w("ct_model_b", dataout_a, aes_ref(PT_B, {KEY_B, 128'h0}, 4));
        handshake(0);

        // C.1 then a second block accepted on the handshake edge
        encrypt(0, PT_C, {KEY_C1, 128'h0}, lat);
        check_i("latency_c1", lat, 10);
        check_w("ct_fips_c1", dataout_a, CT_C1);
        pt2 = rnd128(); k2 = {rnd128(), 128'h0};
        set_in(0, 1'b1, pt2, k2);
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        check_b("b2b_busy", busy_a, 1'b1);
        m = 1;
        while (!out_valid_a && m < 40) begin @(posedge clk); #1; m++; end
        check_i("b2b_spacing", m, 11);
        ct = aes_ref(pt2, k2, 4);
        check_w("ct_b2b", dataout_a, ct);
        @(posedge clk); #1;
        out_ready_a = 1'b0;
        check_b("b2b_idle_out_valid", out_valid_a, 1'b0);
        check_b("b2b_idle_busy", busy_a, 1'b0);
`ifdef AES_ENC_ZEROIZE_EN
        check_w("idle_dataout", dataout_a, 128'h0);
`else
        check_w("idle_dataout", dataout_a, ct);
`endif

        // zeroize/hold behaviour on the C.1 result itself
        encrypt(0, PT_C, {KEY_C1, 128'h0}, lat);
        check_w("ct_fips_c1_again", dataout_a, CT_C1);
        handshake(0);
`ifdef AES_ENC_ZEROIZE_EN
        check_w("idle_dataout_c1", dataout_a, 128'h0);
`else
        check_w("idle_dataout_c1", dataout_a, CT_C1);
`endif

        // backpressure: 20 cycles with out_ready low and random in_valid pulses
        pt = rnd128(); k = {rnd128(), 128'h0};
        ct = aes_ref(pt, k, 4);
        encrypt(0, pt, k, lat);
        check_i("latency_bp", lat, 10);
        for (int i = 0; i < 20; i++) begin
            set_in(0, 1'($urandom_range(0, 1)), rnd128(), {rnd128(), rnd128()});
            #1;
            check_b("bp_in_ready", in_ready_a, 1'b0);
            @(posedge clk); #1;
            check_b("bp_out_valid", out_valid_a, 1'b1);
            check_w("bp_dataout", dataout_a, ct);
        end
        set_in(0, 1'b0, '0, '0);
        handshake(0);
        repeat (3) begin
            @(posedge clk); #1;
            check_b("bp_no_spurious_busy", busy_a, 1'b0);
            check_b("bp_no_spurious_valid", out_valid_a, 1'b0);
        end

        // random AES-128 blocks
        for (int i = 0; i < 3; i++) begin
            pt = rnd128(); k = {rnd128(), 128'h0};
            encrypt(0, pt, k, lat);
            check_i("latency_rand128", lat, 10);
            check_w("ct_rand128", dataout_a, aes_ref(pt, k, 4));
            handshake(0);
        end

        // asynchronous reset while in round 5
        set_in(0, 1'b1, PT_C, {KEY_C1, 128'h0});
        @(posedge clk); #1;
        set_in(0, 1'b0, '0, '0);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_b("midrun_rst_out_valid", out_valid_a, 1'b0);
        check_b("midrun_rst_in_ready", in_ready_a, 1'b0);
        check_b("midrun_rst_busy", busy_a, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_b("post_rst_in_ready", in_ready_a, 1'b1);
        check_b("post_rst_out_valid", out_valid_a, 1'b0);
        encrypt(0, PT_C, {KEY_C1, 128'h0}, lat);
        check_i("latency_post_rst", lat, 10);
        check_w("ct_post_rst", dataout_a, CT_C1);
        handshake(0);

        // AES-256, FIPS-197 C.3
        encrypt(1, PT_C, KEY_C3, lat);
        check_i("latency_c3", lat, 14);
        check_w("ct_fips_c3", dataout_b, CT_C3);
        check_w("ct_model_c3", dataout_b, aes_ref(PT_C, KEY_C3, 8));
        handshake(1);

        // random AES-256 blocks
        for (int i = 0; i < 3; i++) begin
            pt = rnd128(); k = {rnd128(), rnd128()};
            encrypt(1, pt, k, lat);
            check_i("latency_rand256", lat, 14);
            check_w("ct_rand256", get_do(1), aes_ref(pt, k, 8));
            handshake(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
